fetch_unit: RTL

//  Instruction fetch stage that sits directly upstream of the control-unit decoder.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_queue.sv | 66 ++++++
 rtl/fetch_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
package cpu_pkg;

  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0;

  // One prefetched instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries. Push and pop in the same cycle are
// allowed even when full; clear empties the queue and beats any push.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       clear,
  output fetch_entry_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero while empty so decode never sees a stale word.
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !clear) begin
      mem[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order memory requests,
// buffers returned words and hands {instr, pc, pc+8} to decode. A redirect
// flushes the queue and marks every in-flight response to be dropped.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] instr_pcplus8,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic              started;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     q_count;
  logic [CW:0]       slots_used;
  logic              q_full;
  logic              q_empty;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] target_pc;
  logic              unused_redirect_lsb;
  fetch_entry_t      push_entry;
  fetch_entry_t      q_head;

  // Word-aligned redirect target; the two low address bits carry no meaning.
  assign target_pc           = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Every outstanding request owns a queue slot, so the queue cannot overflow.
  assign slots_used     = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req_valid = started && !redirect_valid && !q_full &&
                          (slots_used < (CW + 1)'(DEPTH));
  assign imem_addr      = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push       = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign push_entry = '{instr: imem_rsp_data, pc: resp_pc};
  assign pop        = instr_valid && instr_ready;

  assign instr_valid   = !q_empty;
  assign instr         = q_head.instr;
  assign instr_pc      = q_head.pc;
  assign instr_pcplus8 = instr_pc + ADDR_W'(8);

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .clear      (redirect_valid),
    .head       (q_head),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count)
  );

  // PC tracking plus outstanding/drop accounting; redirect overrides all.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started     <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        // Everything still in flight is stale; a response landing now is
        // already being discarded, so it is not counted again.
        drop     <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
        if (push)     resp_pc  <= resp_pc + ADDR_W'(4);
        if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

endmodule
